rn_stage_queue: RTL and testbench
=================================

Name: rn_stage_queue

Overview:
Parametrised successor to the single-slot decode-to-rename pipeline register. It is a LANES-wide, DEPTH-entry group queue between ID and RN. Each entry holds one decode group of up to LANES instructions with a per-lane valid mask. Per-stage stall is replaced by a valid/ready handshake on both sides, so back-pressure does not collapse into a single global stall. It also adds a flush-discard statistic.

Parameters:
LANES, 2, instructions per decode group (1..4)
PAYLOAD_W, 64, bits per lane (PC, inst and decoded control fields packed by ID)
DEPTH, 2, group entries held (>=2 for full throughput; power of two)
CNT_W, 16, width of the saturating flush-discard counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
EN  in  1  global enable; low freezes all state
flush  in  1  synchronous flush (mispredict/exception redirect)
in_valid  in  LANES  per-lane valid of the incoming ID group
in_payload  in  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W]
in_ready  out  1  queue can accept a group this cycle
out_valid  out  LANES  per-lane valid of the head group presented to RN
out_payload  out  LANES*PAYLOAD_W  head-group payload; zeroed on invalid lanes
out_ready  in  1  RN consumes the head group this cycle
occupancy  out  $clog2(DEPTH+1)  number of groups held
flush_drops  out  CNT_W  saturating count of valid lanes discarded by flush

Behaviour:
- Reset (rst=0, asynchronous): count, wr_ptr, rd_ptr, all stored masks, all payloads and flush_drops go to 0. The outputs are then in_ready=1 (once rst=1 and EN=1), out_valid=0, out_payload=0, occupancy=0.
- in_ready = EN & (count < DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- in_fire = in_ready & (|in_valid). A group with all lanes invalid is never stored.
- out_valid = (EN & count!=0) ? mask[rd_ptr] : 0. Lanes with mask bit 0 drive payload 0, which matches the flush-bubble convention of zero instruction and zero control.
- out_fire = EN & (count!=0) & out_ready. The head group is consumed whole; partial lane consumption is not supported.
- Latency: one cycle. A group accepted at edge N is visible on out_* after edge N.
- Storage is a circular buffer. On in_fire, mask[wr_ptr]<=in_valid, data[wr_ptr]<=in_payload, and wr_ptr increments. On out_fire, rd_ptr increments. Both pointers wrap from DEPTH-1 to 0.
- Simultaneous in_fire and out_fire: count is unchanged. When count==DEPTH-1 and both fire, the queue stays at DEPTH-1 with no loss.
- Full (count==DEPTH): in_ready=0, and the input group is held by ID.
- Empty: out_valid=0, and out_ready is ignored.
- flush=1 (with EN=1) has priority over enqueue and dequeue in the same cycle:
  - count, wr_ptr, rd_ptr and all masks go to 0.
  - Payload storage is not cleared.
  - flush_drops increases by popcount of all stored valid lanes, plus popcount(in_valid) if in_ready was 1, saturating at 2^CNT_W-1.
  - The next cycle: out_valid=0, in_ready=1.
- EN=0: no enqueue, dequeue, flush or counter update. Pointers, masks and payloads are held. in_ready=0 and out_valid=0 while EN is low, and the contents reappear unchanged when EN rises.
- Reset asserted mid-operation discards everything immediately, with no flush_drops increment.

Decomposition:
- Shared package rn_pkg:
  - LANES/PAYLOAD_W defaults.
  - Payload field offsets (PC, inst, OpCode, FUType, RegWrite, ImmSel, OpASel, OpBSel, ALUCtrl, MemCtrl, BraCtrl).
  - Packed lane typedef.
  - popcount function.
- One sub-module, rn_grp_mem: a DEPTH x (LANES + LANES*PAYLOAD_W) register array with write port and asynchronous read port. Pointer/count control and flush_drops stay in the top.

Test Plan:
- Reset then enqueue group {v=2'b11, lane0=0x1000/0x00000013, lane1=0x1004/0x00100093} with out_ready=1 -> next cycle out_valid=2'b11 with matching payload; occupancy=1, then 0.
- Hold out_ready=0 and offer 3 groups -> two accepted, occupancy=2, in_ready=0. Raise out_ready -> groups emerge in order, in_ready returns to 1 after the first out_fire.
- Partial group v=2'b01 -> out_valid=2'b01 and lane1 out_payload=0. An all-invalid input group -> occupancy stays 0.
- Queue holding masks 2'b11 and 2'b10 plus flush with in_valid=2'b11 and in_ready=1 -> next cycle occupancy=0, out_valid=0, flush_drops=5. Flush while full and out_ready=1 -> no dequeue observed.
- EN=0 for 3 cycles with occupancy=2 and toggling in/out -> in_ready=0, out_valid=0, flush ignored. After EN=1 -> same two groups emerge unchanged.
- Pre-load flush_drops to near max (CNT_W=4, repeated flushes) -> saturates at 15. rst pulsed low mid-transfer -> all outputs are 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/rn_pkg.sv
// ---------------------------------------------------------------------------
// rn_pkg
// Shared definitions for the ID -> RN group queue.
//   - default lane count and per-lane payload width
//   - bit offsets of the fields ID packs into one lane payload
//   - packed lane typedef matching those offsets
//   - popcount helper used for the flush-discard statistic
// ---------------------------------------------------------------------------
package rn_pkg;

    localparam int RN_LANES     = 2;
    localparam int RN_PAYLOAD_W = 64;

    // Lane payload layout (LSB first). OpCode is the low 7 bits of inst.
    localparam int INST_LSB     = 0;
    localparam int INST_W       = 32;
    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_W     = 7;
    localparam int PC_LSB       = 32;
    localparam int PC_W         = 16;
    localparam int FUTYPE_LSB   = 48;
    localparam int FUTYPE_W     = 2;
    localparam int REGWRITE_LSB = 50;
    localparam int IMMSEL_LSB   = 51;
    localparam int IMMSEL_W     = 3;
    localparam int OPASEL_LSB   = 54;
    localparam int OPBSEL_LSB   = 55;
    localparam int ALUCTRL_LSB  = 56;
    localparam int ALUCTRL_W    = 4;
    localparam int MEMCTRL_LSB  = 60;
    localparam int MEMCTRL_W    = 2;
    localparam int BRACTRL_LSB  = 62;
    localparam int BRACTRL_W    = 2;

    // One lane as ID packs it; declared MSB first so it lines up with
    // the offsets above when viewed as a flat 64-bit vector.
    typedef struct packed {
        logic [BRACTRL_W-1:0] bra_ctrl;
        logic [MEMCTRL_W-1:0] mem_ctrl;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 op_b_sel;
        logic                 op_a_sel;
        logic [IMMSEL_W-1:0]  imm_sel;
        logic                 reg_write;
        logic [FUTYPE_W-1:0]  fu_type;
        logic [PC_W-1:0]      pc;
        logic [INST_W-1:0]    inst;
    } rn_lane_t;

    // Number of set bits in a lane mask (masks are at most 4 lanes wide,
    // callers zero-extend to 8 bits).
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rn_stage_queue_if.sv
// ---------------------------------------------------------------------------
// rn_stage_queue_if
// Handshake bundle between ID, the group queue and RN.
//   in_valid   per-lane valid of the ID group
//   in_payload ID group payload, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   in_ready   queue can take a group this cycle
//   out_valid  per-lane valid of the head group shown to RN
//   out_payload head-group payload, zero on invalid lanes
//   out_ready  RN consumes the head group
// slave  : the queue's view
// master : the surrounding pipeline's view (ID source + RN sink)
// ---------------------------------------------------------------------------
interface rn_stage_queue_if #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 64
);
    logic [LANES-1:0]           in_valid;
    logic [LANES*PAYLOAD_W-1:0] in_payload;
    logic                       in_ready;
    logic [LANES-1:0]           out_valid;
    logic [LANES*PAYLOAD_W-1:0] out_payload;
    logic                       out_ready;

    modport slave (
        input  in_valid, in_payload, out_ready,
        output in_ready, out_valid, out_payload
    );

    modport master (
        output in_valid, in_payload, out_ready,
        input  in_ready, out_valid, out_payload
    );
endinterface

// File: rtl/rn_grp_mem.sv
// ---------------------------------------------------------------------------
// rn_grp_mem
// DEPTH entries of (lane mask + LANES payloads). One write port, one
// asynchronous read port for the payload, and every mask exposed flat so
// the controller can count stored valid lanes on a flush.
//   clk, rst     clock, asynchronous active-low reset (clears everything)
//   we, waddr    write enable / entry index
//   wmask, wdata mask and payload written at waddr
//   clr_mask     clears every mask, payloads are kept
//   raddr, rdata asynchronous payload read
//   mask_all     all masks, entry i at [i*LANES +: LANES]
// ---------------------------------------------------------------------------
module rn_grp_mem #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 2,
    parameter int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       clr_mask,
    input  logic [PTR_W-1:0]           waddr,
    input  logic [LANES-1:0]           wmask,
    input  logic [LANES*PAYLOAD_W-1:0] wdata,
    input  logic [PTR_W-1:0]           raddr,
    output logic [LANES*PAYLOAD_W-1:0] rdata,
    output logic [DEPTH*LANES-1:0]     mask_all
);

    logic [LANES-1:0]           mask_q [DEPTH];
    logic [LANES*PAYLOAD_W-1:0] data_q [DEPTH];

    // Flush only drops the masks; the stale payload is never visible
    // because output lanes are gated by the mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (clr_mask) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else if (we) begin
            mask_q[waddr] <= wmask;
            data_q[waddr] <= wdata;
        end
    end

    assign rdata = data_q[raddr];

    always_comb begin
        mask_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_all[i*LANES +: LANES] = mask_q[i];
        end
    end

endmodule

// File: rtl/rn_stage_queue.sv
// ---------------------------------------------------------------------------
// rn_stage_queue
// DEPTH-entry queue of LANES-wide decode groups between ID and RN with
// valid/ready on both sides, synchronous flush and a saturating count of
// valid lanes thrown away by flushes.
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   EN          global enable, low freezes all state
//   flush       redirect; discards everything held plus the offered group
//   q           handshake bundle (slave modport)
//   occupancy   number of groups held
//   flush_drops saturating count of valid lanes discarded by flush
// ---------------------------------------------------------------------------
module rn_stage_queue
    import rn_pkg::*;
#(
    parameter int LANES     = RN_LANES,
    parameter int PAYLOAD_W = RN_PAYLOAD_W,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       EN,
    input  logic                       flush,
    rn_stage_queue_if.slave            q,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           flush_drops
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [OCC_W-1:0]           count;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [DEPTH*LANES-1:0]     mask_all;
    logic [LANES*PAYLOAD_W-1:0] rd_data;
    logic [LANES-1:0]           rd_mask;
    logic                       not_empty;
    logic                       in_ready_w;
    logic                       in_fire;
    logic                       out_fire;
    logic [15:0]                drop_sum;
    logic [31:0]                drop_ext;
    logic [CNT_W-1:0]           drops_next;

    // in_ready depends on registered state only, so RN back-pressure
    // never forms a combinational loop back into ID.
    assign not_empty  = (count != '0);
    assign in_ready_w = EN && (count < OCC_W'(DEPTH));
    assign in_fire    = in_ready_w && (|q.in_valid);
    assign out_fire   = EN && not_empty && q.out_ready;
    assign q.in_ready = in_ready_w;
    assign occupancy  = count;

    rn_grp_mem #(
        .LANES     (LANES),
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (in_fire && !flush),
        .clr_mask (EN && flush),
        .waddr    (wr_ptr),
        .wmask    (q.in_valid),
        .wdata    (q.in_payload),
        .raddr    (rd_ptr),
        .rdata    (rd_data),
        .mask_all (mask_all)
    );

    assign rd_mask = mask_all[rd_ptr*LANES +: LANES];

    // Head group presentation; invalid lanes read as a zero bubble.
    always_comb begin
        q.out_valid   = (EN && not_empty) ? rd_mask : '0;
        q.out_payload = '0;
        for (int i = 0; i < LANES; i++) begin
            if (q.out_valid[i]) begin
                q.out_payload[i*PAYLOAD_W +: PAYLOAD_W] = rd_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Lanes lost to a flush: only occupied entries count (consumed entries
    // keep a stale mask), plus the offered group if it would have been taken.
    always_comb begin
        drop_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count)) begin
                drop_sum = drop_sum + 16'(popcount(8'(
                    mask_all[((int'(rd_ptr) + k) % DEPTH)*LANES +: LANES])));
            end
        end
        if (in_ready_w) begin
            drop_sum = drop_sum + 16'(popcount(8'(q.in_valid)));
        end
        drop_ext   = 32'(flush_drops) + 32'(drop_sum);
        drops_next = (drop_ext > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_ext);
    end

    // Pointer/count control; flush wins over enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            flush_drops <= '0;
        end else if (EN) begin
            if (flush) begin
                count       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                flush_drops <= drops_next;
            end else begin
                if (in_fire) begin
                    wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (out_fire) begin
                    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                if (in_fire && !out_fire) begin
                    count <= count + 1'b1;
                end else if (!in_fire && out_fire) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rn_stage_queue.sv
// ---------------------------------------------------------------------------
// tb_rn_stage_queue
// Scoreboard bench for rn_stage_queue (LANES=2, PAYLOAD_W=64, DEPTH=4,
// CNT_W=4 so the discard counter saturates quickly). Accepted groups are
// pushed to a queue, popped when RN consumes them.
// ---------------------------------------------------------------------------
module tb_rn_stage_queue;
    import rn_pkg::*;

    localparam int LANES = 2;
    localparam int PW    = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int DW    = LANES * PW;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [LANES-1:0] mask;
        logic [DW-1:0]    data;
    } grp_t;

    logic clk;
    logic rst;
    logic EN;
    logic flush;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CNT_W-1:0]           flush_drops;

    rn_stage_queue_if #(.LANES(LANES), .PAYLOAD_W(PW)) qif ();

    rn_stage_queue #(
        .LANES     (LANES),
        .PAYLOAD_W (PW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .EN          (EN),
        .flush       (flush),
        .q           (qif),
        .occupancy   (occupancy),
        .flush_drops (flush_drops)
    );

    grp_t sb[$];
    int   exp_drops;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkLane(input logic [15:0] pc, input logic [31:0] inst);
        rn_lane_t l;
        l = '0;
        l.pc   = pc;
        l.inst = inst;
        return l;
    endfunction

    function automatic logic [DW-1:0] maskData(input logic [LANES-1:0] m, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) r[i*PW +: PW] = d[i*PW +: PW];
        end
        return r;
    endfunction

    // Called at a falling edge: drive, check combinational outputs, advance
    // the model with what should fire, clock, then check registered state.
    task automatic applyStimulus(input logic en_i, input logic flush_i, input logic [LANES-1:0] v,
                                 input logic [DW-1:0] data, input logic ordy);
        logic          exp_rdy;
        logic [1:0]    exp_ov;
        logic [DW-1:0] exp_op;
        grp_t          g;
        int            sum;
        EN             = en_i;
        flush          = flush_i;
        qif.in_valid   = v;
        qif.in_payload = data;
        qif.out_ready  = ordy;
        #1;
        exp_rdy = en_i && (sb.size() < DEPTH);
        exp_ov  = '0;
        exp_op  = '0;
        if (en_i && sb.size() != 0) begin
            exp_ov = sb[0].mask;
            exp_op = maskData(sb[0].mask, sb[0].data);
        end
        checkOutput("in_ready", DW'(qif.in_ready), DW'(exp_rdy));
        checkOutput("out_valid", DW'(qif.out_valid), DW'(exp_ov));
        checkOutput("out_payload", qif.out_payload, exp_op);
        if (en_i) begin
            if (flush_i) begin
                sum = 0;
                foreach (sb[i]) sum += $countones(sb[i].mask);
                if (exp_rdy) sum += $countones(v);
                exp_drops = (exp_drops + sum > CMAX) ? CMAX : exp_drops + sum;
                sb.delete();
            end else begin
                if (ordy && sb.size() != 0) void'(sb.pop_front());
                if (exp_rdy && (|v)) begin
                    g.mask = v;
                    g.data = data;
                    sb.push_back(g);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("occupancy", DW'(occupancy), DW'(sb.size()));
        checkOutput("flush_drops", DW'(flush_drops), DW'(exp_drops));
    endtask

    function automatic logic [DW-1:0] grp(input int i);
        return {mkLane(16'h2004 + 16'(8*i), 32'h00200093 + i), mkLane(16'h2000 + 16'(8*i), 32'h00100013 + i)};
    endfunction

    initial begin
        logic [DW-1:0] g0;
        errors         = 0;
        checks         = 0;
        exp_drops      = 0;
        rst            = 1'b0;
        EN             = 1'b1;
        flush          = 1'b0;
        qif.in_valid   = '0;
        qif.in_payload = '0;
        qif.out_ready  = 1'b0;
        #3;
        checkOutput("rst_occupancy", DW'(occupancy), '0);
        checkOutput("rst_out_valid", DW'(qif.out_valid), '0);
        checkOutput("rst_out_payload", qif.out_payload, '0);
        checkOutput("rst_flush_drops", DW'(flush_drops), '0);
        @(negedge clk);
        rst = 1'b1;

        // Single full group passes with one cycle of latency.
        g0 = {mkLane(16'h1004, 32'h00100093), mkLane(16'h1000, 32'h00000013)};
        applyStimulus(1, 0, 2'b11, g0, 1);
        applyStimulus(1, 0, 2'b00, '0, 1);

        // Back-pressure: fill, one offer refused while full, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 2'b11, grp(i), 0);
        applyStimulus(1, 0, 2'b11, grp(DEPTH), 1);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 2'b00, '0, 1);

        // Partial group, then an all-invalid group that must not be stored.
        applyStimulus(1, 0, 2'b01, {mkLane(16'h3004, 32'hdeadbeef), mkLane(16'h3000, 32'h13)}, 0);
        applyStimulus(1, 0, 2'b00, {mkLane(16'h4004, 32'h1111), mkLane(16'h4000, 32'h2222)}, 1);
        applyStimulus(1, 0, 2'b00, '1, 1);

        // Flush with masks 11 and 10 held plus an acceptable 11 offer: 5 lanes.
        applyStimulus(1, 0, 2'b11, grp(5), 0);
        applyStimulus(1, 0, 2'b10, grp(6), 0);
        applyStimulus(1, 1, 2'b11, grp(7), 0);
        applyStimulus(1, 0, 2'b00, '0, 1);

        // Enable low freezes everything, then the same groups come out.
        applyStimulus(1, 0, 2'b11, grp(8), 0);
        applyStimulus(1, 0, 2'b01, grp(9), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, i[0], 2'b11 ^ LANES'(i), grp(10 + i), i[0]);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2'b00, '0, 1);

        // Flush while full with out_ready high: no dequeue, offer not counted.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 2'b11, grp(20 + i), 0);
        applyStimulus(1, 1, 2'b11, grp(30), 1);
        applyStimulus(1, 0, 2'b00, '0, 0);

        // Drive the counter into saturation.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 2'b11, grp(40 + i), 0);
            applyStimulus(1, 1, 2'b11, grp(50 + i), 0);
        end

        // Asynchronous reset mid-transfer clears outputs before any edge.
        applyStimulus(1, 0, 2'b11, grp(60), 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_out_valid", DW'(qif.out_valid), '0);
        checkOutput("arst_out_payload", qif.out_payload, '0);
        checkOutput("arst_occupancy", DW'(occupancy), '0);
        checkOutput("arst_flush_drops", DW'(flush_drops), '0);
        sb.delete();
        exp_drops = 0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 0, 2'b10, grp(61), 1);
        applyStimulus(1, 0, 2'b00, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
